magnitude_search_4bit: RTL
==========================

MAGNITUDE_SEARCH_4BIT -- requirements
Module: magnitude_search_4bit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port start  input  1  request a new search; sampled on rising clk.
REQ-004 SHALL have port alb  input  1  external comparator flag: guess < hidden target.
REQ-005 SHALL have port aeb  input  1  external comparator flag: guess == hidden target.
REQ-006 SHALL have port agb  input  1  external comparator flag: guess > hidden target.
REQ-007 SHALL have port guess  output  4  probe value driven to the external comparator's a input.
REQ-008 SHALL have port busy  output  1  high while in SEARCH.
REQ-009 SHALL have port done  output  1  high while in DONE.
REQ-010 SHALL have port result  output  4  located target value; valid when done=1 and error=0.
REQ-011 SHALL have port steps  output  3  number of probes evaluated in the last search (1..5).
REQ-012 SHALL have port error  output  1  last search aborted on inconsistent comparator flags.

Function
REQ-013 SHALL implement states IDLE, SEARCH, DONE, plus internal 4-bit bounds lo and hi.
REQ-014 SHALL drive guess = floor((lo+hi)/2), using a 5-bit intermediate sum, while in SEARCH, and 0 otherwise.
REQ-015 SHALL treat the external comparator as combinational: flags SHALL be sampled at the same edge on which the current guess is evaluated.
REQ-016 IDLE or DONE with start=1 SHALL load lo=0 and hi=15, clear steps, error and result, and enter SEARCH.
REQ-017 SEARCH with start=1 SHALL ignore start, with no restart.
REQ-018 SEARCH, each edge: steps increments by 1, and exactly one branch is taken:
- aeb only: result=guess, go to DONE.
- alb only and guess<hi: lo=guess+1.
- agb only and guess>lo: hi=guess-1.
REQ-019 SEARCH with flags not exactly one-hot, alb with guess==hi, or agb with guess==lo SHALL set error=1, result=0, and go to DONE.
REQ-020 A search SHALL complete in at most 5 SEARCH cycles for any consistent target 0..15.
- Latency from the start edge to done=1 equals steps, in cycles.
REQ-021 DONE SHALL hold result, steps and error stable until the next accepted start.
REQ-022 IDLE SHALL be entered only via reset; DONE SHALL persist until start.
REQ-023 busy and done SHALL never be high simultaneously.

Reset
REQ-024 rst=1 at a rising edge SHALL force the following, regardless of state or start:
- IDLE, lo=0, hi=15;
- guess=0, busy=0, done=0, result=0, steps=0, error=0.
REQ-025 rst asserted mid-SEARCH SHALL abandon the search, with no done pulse and result unchanged from its reset value 0.
REQ-026 rst and start both high on the same edge SHALL resolve to reset; start is ignored.

Verification
REQ-027 Bench model: alb/aeb/agb are computed combinationally from guess vs target.
- Target 7, pulse start -> guess=7 in the next cycle; done=1 after 1 cycle with result=7, steps=1, error=0.
REQ-028 Target 15 -> guess sequence 7, 11, 13, 14, 15, then done with result=15, steps=5.
- Target 0 -> sequence 7, 3, 1, 0, then result=0, steps=4.
REQ-029 Sweep targets 0..15 back-to-back, restarting from DONE each time -> result==target, steps<=5, error=0 every time.
REQ-030 Force alb=aeb=1 on the first probe -> done=1, error=1, result=0, steps=1.
- Force alb=1 constantly -> error=1 at guess=15, steps=5.
REQ-031 Assert start again during SEARCH -> the search is unaffected.
- Assert rst during the third probe -> all outputs 0 and state IDLE on the next cycle; a subsequent start works normally.

Source files
------------

// File: rtl/magnitude_search_4bit.sv
// Binary search over 0..15 driven by an external combinational comparator.
// Each SEARCH cycle evaluates one probe; inconsistent comparator flags abort to DONE with error set.
module magnitude_search_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       alb,
  input  logic       aeb,
  input  logic       agb,
  output logic [3:0] guess,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic [2:0] steps,
  output logic       error
);

  localparam int unsigned VAL_W  = 4;
  localparam int unsigned SUM_W  = VAL_W + 1;
  localparam int unsigned STEP_W = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t             r_state,  w_state_nxt;
  logic [VAL_W-1:0]   r_lo,     w_lo_nxt;
  logic [VAL_W-1:0]   r_hi,     w_hi_nxt;
  logic [VAL_W-1:0]   r_result, w_result_nxt;
  logic [STEP_W-1:0]  r_steps,  w_steps_nxt;
  logic               r_error,  w_error_nxt;

  logic [SUM_W-1:0]   w_sum;
  logic [VAL_W-1:0]   w_mid;
  logic [2:0]         w_flags;

  // Midpoint of the current bounds; the extra sum bit keeps lo+hi from wrapping
  assign w_sum   = SUM_W'(r_lo) + SUM_W'(r_hi);
  assign w_mid   = w_sum[SUM_W-1:1];
  assign w_flags = {alb, aeb, agb};

  assign guess  = (r_state == S_SEARCH) ? w_mid : VAL_W'(0);
  assign busy   = (r_state == S_SEARCH);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign steps  = r_steps;
  assign error  = r_error;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_lo     <= VAL_W'(0);
      r_hi     <= VAL_W'(15);
      r_result <= VAL_W'(0);
      r_steps  <= STEP_W'(0);
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_lo     <= w_lo_nxt;
      r_hi     <= w_hi_nxt;
      r_result <= w_result_nxt;
      r_steps  <= w_steps_nxt;
      r_error  <= w_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_lo_nxt     = r_lo;
    w_hi_nxt     = r_hi;
    w_result_nxt = r_result;
    w_steps_nxt  = r_steps;
    w_error_nxt  = r_error;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt  = S_SEARCH;
          w_lo_nxt     = VAL_W'(0);
          w_hi_nxt     = VAL_W'(15);
          w_result_nxt = VAL_W'(0);
          w_steps_nxt  = STEP_W'(0);
          w_error_nxt  = 1'b0;
        end
      end
      S_SEARCH: begin
        // start is deliberately ignored here: a running search cannot be restarted
        w_steps_nxt = STEP_W'(r_steps + STEP_W'(1));
        if (w_flags == 3'b010) begin
          w_result_nxt = w_mid;
          w_state_nxt  = S_DONE;
        end else if (w_flags == 3'b100 && w_mid < r_hi) begin
          w_lo_nxt = VAL_W'(w_mid + VAL_W'(1));
        end else if (w_flags == 3'b001 && w_mid > r_lo) begin
          w_hi_nxt = VAL_W'(w_mid - VAL_W'(1));
        end else begin
          w_error_nxt  = 1'b1;
          w_result_nxt = VAL_W'(0);
          w_state_nxt  = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
